// File: rtl/i2s_pkg.sv
// Shared types for the I2S DAC transmitter: the serializer FSM states and
// the channel encoding.
package i2s_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} i2s_tx_state_e;
  typedef enum logic {CH_L, CH_R} i2s_chan_e;

  localparam int I2S_DELAY_BITS = 1;

endpackage

// File: rtl/i2s_sample_buffer.sv
// Per-channel holding registers with fresh tracking; supplies the word for
// each slot load and flags overruns/underruns.
module i2s_sample_buffer
  import i2s_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int MONO          = 1,
  parameter int UNDERRUN_ZERO = 0
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic                     i_chan,
  input  logic signed [DATA_W-1:0] audio_in,
  input  logic                     load_l_i,
  input  logic                     load_r_i,
  output logic signed [DATA_W-1:0] load_data_o,
  output logic                     o_ready,
  output logic                     o_underrun,
  output logic                     o_overrun
);

  logic signed [DATA_W-1:0] hl_q, hl_d, hr_q, hr_d;
  logic fl_q, fl_d, fr_q, fr_d;
  logic ur_q, ur_d, ov_q, ov_d;
  logic tgt_r, sel_r, sel_fresh;
  logic signed [DATA_W-1:0] sel_hold;

  always_comb begin
    tgt_r     = (MONO == 0) && (i2s_chan_e'(i_chan) == CH_R);
    sel_r     = (MONO == 0) && load_r_i;
    sel_fresh = sel_r ? fr_q : fl_q;
    sel_hold  = sel_r ? hr_q : hl_q;
    // The load always reads the pre-write value, so a same-cycle write survives as fresh.
    load_data_o = (sel_fresh || (UNDERRUN_ZERO == 0)) ? sel_hold : '0;
    o_ready     = !(tgt_r ? fr_q : fl_q);

    hl_d = hl_q;
    hr_d = hr_q;
    fl_d = fl_q;
    fr_d = fr_q;
    ur_d = (load_l_i || load_r_i) && !sel_fresh;
    ov_d = i_valid && (tgt_r ? fr_q : fl_q);

    // In mono the single sample must feed both slots, so only the right load consumes it.
    if (load_l_i && (MONO == 0)) fl_d = 1'b0;
    if (load_r_i) begin
      if (MONO != 0) fl_d = 1'b0;
      else           fr_d = 1'b0;
    end

    if (i_valid) begin
      if (tgt_r) begin
        hr_d = audio_in;
        fr_d = 1'b1;
      end else begin
        hl_d = audio_in;
        fl_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      hl_q <= '0;
      hr_q <= '0;
      fl_q <= 1'b0;
      fr_q <= 1'b0;
      ur_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      hl_q <= hl_d;
      hr_q <= hr_d;
      fl_q <= fl_d;
      fr_q <= fr_d;
      ur_q <= ur_d;
      ov_q <= ov_d;
    end
  end

  assign o_underrun = ur_q;
  assign o_overrun  = ov_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: loads a sample on each LRCLK edge strobe and shifts it
// out MSB-first on BCLK falling-edge strobes after the one-bit I2S delay.
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int MONO          = 1,
  parameter int UNDERRUN_ZERO = 0
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     lrclk_negedge,
  input  logic                     lrclk_posedge,
  input  logic                     bclk_negedge,
  input  logic                     i_valid,
  input  logic                     i_chan,
  input  logic signed [DATA_W-1:0] audio_in,
  output logic                     o_ready,
  output logic                     o_dacdat,
  output logic                     o_underrun,
  output logic                     o_overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  i2s_tx_state_e            state_q, state_d;
  logic signed [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     dac_q, dac_d;
  logic                     load_l, load_r, load_any;
  logic signed [DATA_W-1:0] load_data;

  // Simultaneous strobes are illegal; left wins.
  assign load_l   = lrclk_negedge;
  assign load_r   = lrclk_posedge && !lrclk_negedge;
  assign load_any = load_l || load_r;

  i2s_sample_buffer #(
    .DATA_W        (DATA_W),
    .MONO          (MONO),
    .UNDERRUN_ZERO (UNDERRUN_ZERO)
  ) u_buf (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_chan      (i_chan),
    .audio_in    (audio_in),
    .load_l_i    (load_l),
    .load_r_i    (load_r),
    .load_data_o (load_data),
    .o_ready     (o_ready),
    .o_underrun  (o_underrun),
    .o_overrun   (o_overrun)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dac_d   = dac_q;
    // An LRCLK edge restarts the slot from any state; its BCLK edge is the transition edge, not data.
    if (load_any) begin
      shift_d = load_data;
      cnt_d   = '0;
      dac_d   = 1'b0;
      state_d = DELAY;
    end else if (bclk_negedge) begin
      unique case (state_q)
        IDLE: dac_d = 1'b0;
        DELAY: begin
          dac_d   = shift_q[DATA_W-1];
          shift_d = shift_q << 1;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == CNT_W'(DATA_W)) begin
            dac_d   = 1'b0;
            state_d = PAD;
          end else begin
            dac_d   = shift_q[DATA_W-1];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        PAD: dac_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      dac_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dac_q   <= dac_d;
    end
  end

  assign o_dacdat = dac_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: three configurations (mono, stereo resend, stereo zero-fill)
// driven by one directed stimulus stream and checked against a slot-level model.
module tb_i2s_dac_tx;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, lneg = 1'b0, lpos = 1'b0, bneg = 1'b0, valid = 1'b0, chan = 1'b0;
  logic signed [DW-1:0] din = '0;

  logic dac0, dac1, dac2, rdy0, rdy1, rdy2, ur0, ur1, ur2, ov0, ov1, ov2;
  logic dac_a[3], rdy_a[3], ur_a[3], ov_a[3];
  assign dac_a[0] = dac0; assign dac_a[1] = dac1; assign dac_a[2] = dac2;
  assign rdy_a[0] = rdy0; assign rdy_a[1] = rdy1; assign rdy_a[2] = rdy2;
  assign ur_a[0]  = ur0;  assign ur_a[1]  = ur1;  assign ur_a[2]  = ur2;
  assign ov_a[0]  = ov0;  assign ov_a[1]  = ov1;  assign ov_a[2]  = ov2;

  i2s_dac_tx #(.DATA_W(DW), .MONO(1), .UNDERRUN_ZERO(0)) u_mono (
    .clk(clk), .i_rst(rst), .lrclk_negedge(lneg), .lrclk_posedge(lpos), .bclk_negedge(bneg),
    .i_valid(valid), .i_chan(chan), .audio_in(din),
    .o_ready(rdy0), .o_dacdat(dac0), .o_underrun(ur0), .o_overrun(ov0));
  i2s_dac_tx #(.DATA_W(DW), .MONO(0), .UNDERRUN_ZERO(0)) u_st (
    .clk(clk), .i_rst(rst), .lrclk_negedge(lneg), .lrclk_posedge(lpos), .bclk_negedge(bneg),
    .i_valid(valid), .i_chan(chan), .audio_in(din),
    .o_ready(rdy1), .o_dacdat(dac1), .o_underrun(ur1), .o_overrun(ov1));
  i2s_dac_tx #(.DATA_W(DW), .MONO(0), .UNDERRUN_ZERO(1)) u_stz (
    .clk(clk), .i_rst(rst), .lrclk_negedge(lneg), .lrclk_posedge(lpos), .bclk_negedge(bneg),
    .i_valid(valid), .i_chan(chan), .audio_in(din),
    .o_ready(rdy2), .o_dacdat(dac2), .o_underrun(ur2), .o_overrun(ov2));

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst%0d actual=%h required=%h", name, k, act, req);
    end
  endfunction

  function automatic bit mono_f(int k); return k == 0; endfunction
  function automatic bit uz_f(int k);   return k == 2; endfunction

  // Slot-level model: holding words, fresh flags, and the BCLK index within the slot.
  logic [DW-1:0] m_hl[3], m_hr[3], m_slot[3];
  bit  m_fl[3], m_fr[3], m_act[3];
  int  m_idx[3];
  bit  e_dac[3], e_ur[3], e_ov[3];
  bit  started = 1'b0;
  int  cap_idx = 1000;
  bit  cap_left = 1'b1;

  bit mr_tgt, mr_fo, mr_isr, mr_f;
  logic [DW-1:0] mr_h;

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_hl[k] = '0; m_hr[k] = '0; m_slot[k] = '0;
        m_fl[k] = 1'b0; m_fr[k] = 1'b0; m_act[k] = 1'b0; m_idx[k] = 0;
        e_dac[k] = 1'b0; e_ur[k] = 1'b0; e_ov[k] = 1'b0;
      end else begin
        e_ur[k] = 1'b0;
        e_ov[k] = 1'b0;
        mr_tgt = !mono_f(k) && chan;
        mr_fo  = mr_tgt ? m_fr[k] : m_fl[k];
        if (lneg || lpos) begin
          mr_isr = !lneg && !mono_f(k);
          mr_f   = mr_isr ? m_fr[k] : m_fl[k];
          mr_h   = mr_isr ? m_hr[k] : m_hl[k];
          m_slot[k] = (mr_f || !uz_f(k)) ? mr_h : '0;
          e_ur[k] = !mr_f;
          if (!mono_f(k) || !lneg) begin
            if (mr_isr) m_fr[k] = 1'b0; else m_fl[k] = 1'b0;
          end
          m_idx[k] = 0;
          m_act[k] = 1'b1;
          e_dac[k] = 1'b0;
        end else if (bneg && m_act[k]) begin
          m_idx[k]++;
          e_dac[k] = (m_idx[k] >= 1 && m_idx[k] <= DW) ? m_slot[k][DW - m_idx[k]] : 1'b0;
        end
        if (valid) begin
          e_ov[k] = mr_fo;
          if (mr_tgt) begin m_hr[k] = din; m_fr[k] = 1'b1; end
          else        begin m_hl[k] = din; m_fl[k] = 1'b1; end
        end
      end
    end
    if (rst) cap_idx = 1000;
    else if (lneg || lpos) begin cap_idx = 0; cap_left = lneg; end
    else if (bneg) cap_idx++;
    started = 1'b1;
  end

  int ur_cnt[3] = '{0, 0, 0};
  int ov_cnt[3] = '{0, 0, 0};
  logic [DW-1:0] cap_l[3], cap_r[3];
  bit exp_rdy;

  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        exp_rdy = !((!mono_f(k) && chan) ? m_fr[k] : m_fl[k]);
        chk("dacdat", k, 32'(dac_a[k]), 32'(e_dac[k]));
        chk("ready", k, 32'(rdy_a[k]), 32'(exp_rdy));
        chk("underrun", k, 32'(ur_a[k]), 32'(e_ur[k]));
        chk("overrun", k, 32'(ov_a[k]), 32'(e_ov[k]));
        ur_cnt[k] += int'(ur_a[k]);
        ov_cnt[k] += int'(ov_a[k]);
        if (cap_idx == 0) begin
          if (cap_left) cap_l[k] = '0; else cap_r[k] = '0;
        end else if (cap_idx >= 1 && cap_idx <= DW) begin
          if (cap_left) cap_l[k][DW - cap_idx] = dac_a[k];
          else          cap_r[k][DW - cap_idx] = dac_a[k];
        end
      end
    end
  end

  int ur_s[3], ov_s[3];

  task automatic snap();
    for (int k = 0; k < 3; k++) begin ur_s[k] = ur_cnt[k]; ov_s[k] = ov_cnt[k]; end
  endtask

  task automatic tick(input bit bn, input bit ln, input bit lp);
    bneg = bn; lneg = ln; lpos = lp;
    @(posedge clk); #1;
    bneg = 1'b0; lneg = 1'b0; lpos = 1'b0;
  endtask

  task automatic bclk_period(input bit ln, input bit lp);
    tick(1'b1, ln, lp);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic slot(input bit left, input int nb);
    bclk_period(left, !left);
    repeat (nb - 1) bclk_period(1'b0, 1'b0);
  endtask

  task automatic frame();
    slot(1'b1, 32);
    slot(1'b0, 32);
  endtask

  task automatic write(input bit ch, input logic [DW-1:0] d);
    valid = 1'b1; chan = ch; din = d;
    @(posedge clk); #1;
    valid = 1'b0; chan = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_dacdat", k, 32'(dac_a[k]), 32'd0);
      chk("rst_ready", k, 32'(rdy_a[k]), 32'd1);
      chk("rst_underrun", k, 32'(ur_a[k]), 32'd0);
      chk("rst_overrun", k, 32'(ov_a[k]), 32'd0);
    end

    // Stereo words; mono sees the second write as an overrun.
    snap();
    write(1'b0, 16'h1234);
    write(1'b1, 16'hABCD);
    frame();
    chk("t2_left", 1, 32'(cap_l[1]), 32'h1234);
    chk("t2_right", 1, 32'(cap_r[1]), 32'hABCD);
    chk("t2_mono_left", 0, 32'(cap_l[0]), 32'hABCD);
    chk("t2_ov_mono", 0, 32'(ov_cnt[0] - ov_s[0]), 32'd1);
    chk("t2_ov_st", 1, 32'(ov_cnt[1] - ov_s[1]), 32'd0);
    chk("t2_ur_st", 1, 32'(ur_cnt[1] - ur_s[1]), 32'd0);

    // Frame without new samples: resend vs zero-fill.
    snap();
    frame();
    chk("t3_left_resend", 1, 32'(cap_l[1]), 32'h1234);
    chk("t3_right_resend", 1, 32'(cap_r[1]), 32'hABCD);
    chk("t3_ur_resend", 1, 32'(ur_cnt[1] - ur_s[1]), 32'd2);
    chk("t3_left_zero", 2, 32'(cap_l[2]), 32'h0000);
    chk("t3_right_zero", 2, 32'(cap_r[2]), 32'h0000);
    chk("t3_ur_zero", 2, 32'(ur_cnt[2] - ur_s[2]), 32'd2);

    // Mono: one sample feeds both slots.
    snap();
    write(1'b0, 16'h8001);
    frame();
    chk("t1_mono_left", 0, 32'(cap_l[0]), 32'h8001);
    chk("t1_mono_right", 0, 32'(cap_r[0]), 32'h8001);
    chk("t1_mono_ur", 0, 32'(ur_cnt[0] - ur_s[0]), 32'd0);

    // Overrun: second write wins.
    snap();
    write(1'b0, 16'h0001);
    write(1'b0, 16'h7FFF);
    frame();
    chk("t4_left", 1, 32'(cap_l[1]), 32'h7FFF);
    chk("t4_ov", 1, 32'(ov_cnt[1] - ov_s[1]), 32'd1);

    // Short left slot aborted after 8 BCLKs by the right LRCLK edge.
    write(1'b0, 16'h1234);
    write(1'b1, 16'h5A5A);
    slot(1'b1, 8);
    chk("t5_short_bits", 1, 32'(cap_l[1][15:9]), 32'b0001001);
    slot(1'b0, 32);
    chk("t5_right", 1, 32'(cap_r[1]), 32'h5A5A);

    // Reset mid-slot, then idle until the next LRCLK edge.
    write(1'b0, 16'hC0DE);
    bclk_period(1'b1, 1'b0);
    repeat (5) bclk_period(1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t6_rst_dacdat", k, 32'(dac_a[k]), 32'd0);
      chk("t6_rst_ready", k, 32'(rdy_a[k]), 32'd1);
    end
    repeat (10) bclk_period(1'b0, 1'b0);
    chk("t6_idle_dacdat", 1, 32'(dac_a[1]), 32'd0);
    snap();
    write(1'b0, 16'h00FF);
    frame();
    chk("t6_left", 1, 32'(cap_l[1]), 32'h00FF);
    chk("t6_right", 1, 32'(cap_r[1]), 32'h0000);
    chk("t6_ur", 1, 32'(ur_cnt[1] - ur_s[1]), 32'd1);

    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
